alu_seq16: RTL and testbench

- Multi-cycle 16-bit arithmetic/shift sequencer. It is the initiator side of the 8-bit ALU interface.
- It splits each 16-bit request into 8-bit micro-ops and drives alu_op, operands and cin into the combinational ALU.
- It consumes the ALU result and {c,n,z} flags and assembles a 16-bit result plus 16-bit flags.
- The ALU does not propagate carry-in, so carry/borrow correction is done here with an extra FIX micro-op.

---
 rtl/alu_seq16_if.sv | 20 ++
 rtl/alu_seq16.sv | 231 +++++++++++++++++++++++
 tb/tb_alu_seq16.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq16_if.sv
// Byte-wide bus between the 16-bit sequencer (master) and the combinational 8-bit ALU (slave).
// Micro-op and operands go out; result and {c,n,z} come back in the same cycle.
interface alu_seq16_if;
  logic [3:0] alu_op;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic       alu_cin;
  logic [7:0] alu_out;
  logic [2:0] alu_flags;

  modport master (
    output alu_op, alu_a, alu_b, alu_cin,
    input  alu_out, alu_flags
  );

  modport slave (
    input  alu_op, alu_a, alu_b, alu_cin,
    output alu_out, alu_flags
  );
endinterface

// File: rtl/alu_seq16.sv
// 16-bit add/sub/shift built from 8-bit ALU micro-ops (LO, HI, optional FIX); done 3 or 4 cycles after start.
// No backpressure: start is only sampled in IDLE and is dropped in any other state.
module alu_seq16 #(
  parameter bit FIX_SKIP = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic [15:0]   a_in,
  input  logic [15:0]   b_in,
  output logic          busy,
  output logic          done,
  output logic [15:0]   result,
  output logic [2:0]    flags_out,
  alu_seq16_if.master   alu
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_LSL = 2'b10;
  localparam logic [1:0] OP_LSR = 2'b11;

  localparam logic [3:0] UOP_IDLE = 4'b0000;
  localparam logic [3:0] UOP_ADD  = 4'b0001;
  localparam logic [3:0] UOP_SUB  = 4'b0010;
  localparam logic [3:0] UOP_LSL  = 4'b0011;
  localparam logic [3:0] UOP_LSR  = 4'b0100;
  localparam logic [3:0] UOP_OR   = 4'b1000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LO,
    S_HI,
    S_FIX,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [7:0]  lo_q, lo_d;
  logic [7:0]  hi_q, hi_d;
  logic        c_lo_q, c_lo_d;
  logic        c_hi_q, c_hi_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] result_q, result_d;
  logic [2:0]  flags_q, flags_d;
  logic [3:0]  alu_op_q, alu_op_d;
  logic [7:0]  alu_a_q, alu_a_d;
  logic [7:0]  alu_b_q, alu_b_d;

  logic        need_fix;
  logic        c_fix;
  logic        c_res;
  logic [15:0] res_w;
  logic [3:0]  uop_half;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    c_lo_d   = c_lo_q;
    c_hi_d   = c_hi_q;
    result_d = result_q;
    flags_d  = flags_q;
    need_fix = 1'b0;
    // Neutral fix carry when FIX is skipped: 0 for ADD (OR), 1 for SUB (AND).
    c_fix    = (op_q == OP_SUB);
    c_res    = 1'b0;
    res_w    = 16'h0000;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          a_d     = a_in;
          b_d     = b_in;
          state_d = S_LO;
        end
      end
      S_LO: begin
        lo_d    = alu.alu_out;
        c_lo_d  = alu.alu_flags[2];
        state_d = S_HI;
      end
      S_HI: begin
        hi_d     = alu.alu_out;
        c_hi_d   = alu.alu_flags[2];
        need_fix = (op_q == OP_ADD) ? c_lo_q : ~c_lo_q;
        if (op_q[1] || need_fix || !FIX_SKIP) begin
          state_d = S_FIX;
        end else begin
          state_d = S_DONE;
        end
      end
      S_FIX: begin
        if (op_q == OP_LSR) begin
          lo_d = alu.alu_out;
        end else begin
          hi_d = alu.alu_out;
        end
        c_fix   = alu.alu_flags[2];
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_d == S_DONE) begin
      res_w = {hi_d, lo_d};
      case (op_q)
        OP_ADD:  c_res = c_hi_d | c_fix;
        OP_SUB:  c_res = c_hi_d & c_fix;
        OP_LSL:  c_res = a_q[15];
        default: c_res = a_q[0];
      endcase
      result_d = res_w;
      flags_d  = {c_res, res_w[15], (res_w == 16'h0000)};
    end

    busy_d = (state_d == S_LO) || (state_d == S_HI) || (state_d == S_FIX);
    done_d = (state_d == S_DONE);

    case (op_d)
      OP_ADD:  uop_half = UOP_ADD;
      OP_SUB:  uop_half = UOP_SUB;
      OP_LSL:  uop_half = UOP_LSL;
      default: uop_half = UOP_LSR;
    endcase

    // ALU drive is registered, so it is decoded from the state being entered.
    alu_op_d = UOP_IDLE;
    alu_a_d  = 8'h00;
    alu_b_d  = 8'h00;
    case (state_d)
      S_LO: begin
        alu_op_d = uop_half;
        alu_a_d  = a_d[7:0];
        alu_b_d  = op_d[1] ? 8'h01 : b_d[7:0];
      end
      S_HI: begin
        alu_op_d = uop_half;
        alu_a_d  = a_q[15:8];
        alu_b_d  = op_q[1] ? 8'h01 : b_q[15:8];
      end
      S_FIX: begin
        case (op_q)
          OP_ADD: begin
            alu_op_d = UOP_ADD;
            alu_a_d  = hi_d;
            alu_b_d  = {7'b0, c_lo_q};
          end
          OP_SUB: begin
            alu_op_d = UOP_SUB;
            alu_a_d  = hi_d;
            alu_b_d  = {7'b0, ~c_lo_q};
          end
          OP_LSL: begin
            alu_op_d = UOP_OR;
            alu_a_d  = hi_d;
            alu_b_d  = {7'b0, a_q[7]};
          end
          default: begin
            alu_op_d = UOP_OR;
            alu_a_d  = lo_q;
            alu_b_d  = {a_q[8], 7'b0};
          end
        endcase
      end
      default: begin
        alu_op_d = UOP_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= 2'b00;
      a_q      <= 16'h0000;
      b_q      <= 16'h0000;
      lo_q     <= 8'h00;
      hi_q     <= 8'h00;
      c_lo_q   <= 1'b0;
      c_hi_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 16'h0000;
      flags_q  <= 3'b000;
      alu_op_q <= UOP_IDLE;
      alu_a_q  <= 8'h00;
      alu_b_q  <= 8'h00;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      c_lo_q   <= c_lo_d;
      c_hi_q   <= c_hi_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      alu_op_q <= alu_op_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign flags_out   = flags_q;
  assign alu.alu_op  = alu_op_q;
  assign alu.alu_a   = alu_a_q;
  assign alu.alu_b   = alu_b_q;
  assign alu.alu_cin = 1'b0;

endmodule

// File: tb/tb_alu_seq16.sv
// Bench for alu_seq16: two instances (FIX_SKIP=1 and 0) share stimulus, each with its own 8-bit ALU model.
// Results are checked against plain 16-bit arithmetic.
module tb_alu_seq16;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic        busy1, done1, busy0, done0;
  logic [15:0] res1, res0;
  logic [2:0]  fl1, fl0;

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0] prev_res;
  logic [2:0]  prev_fl;

  always #5 clk = ~clk;

  alu_seq16_if bus1();
  alu_seq16_if bus0();

  alu_seq16 #(.FIX_SKIP(1'b1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
    .busy(busy1), .done(done1), .result(res1), .flags_out(fl1), .alu(bus1)
  );

  alu_seq16 #(.FIX_SKIP(1'b0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
    .busy(busy0), .done(done0), .result(res0), .flags_out(fl0), .alu(bus0)
  );

  // Combinational 8-bit ALU: returns {c,n,z,out}.
  function automatic logic [10:0] alu8(input logic [3:0] f, input logic [7:0] x, input logic [7:0] y);
    logic [8:0] t;
    logic [7:0] o;
    logic       c;
    t = 9'h000;
    case (f)
      4'b0001: begin t = x + y; o = t[7:0]; c = t[8]; end
      4'b0010: begin o = x - y; c = (x >= y); end
      4'b0011: begin o = x << 1; c = x[7]; end
      4'b0100: begin o = x >> 1; c = x[0]; end
      4'b1000: begin o = x | y; c = 1'b0; end
      default: begin o = 8'h00; c = 1'b0; end
    endcase
    return {c, o[7], (o == 8'h00), o};
  endfunction

  assign {bus1.alu_flags, bus1.alu_out} = alu8(bus1.alu_op, bus1.alu_a, bus1.alu_b);
  assign {bus0.alu_flags, bus0.alu_out} = alu8(bus0.alu_op, bus0.alu_a, bus0.alu_b);

  // Reference: {c,n,z,result} from 16-bit arithmetic.
  function automatic logic [18:0] ref16(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    logic [15:0] r;
    logic        c;
    case (o)
      2'b00:   begin s = a + b; r = s[15:0]; c = s[16]; end
      2'b01:   begin r = a - b; c = (a >= b); end
      2'b10:   begin r = a << 1; c = a[15]; end
      default: begin r = a >> 1; c = a[0]; end
    endcase
    return {c, r[15], (r == 16'h0000), r};
  endfunction

  function automatic int exp_lat(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b, input bit skip);
    if (!skip || o[1]) return 4;
    if (o == 2'b00) return ((a[7:0] + b[7:0]) > 255) ? 4 : 3;
    return (a[7:0] < b[7:0]) ? 4 : 3;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic launch(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    start = 1'b1; op = o; a_in = a; b_in = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Entered #1 after the edge that accepted start (that cycle is cycle 1).
  task automatic track(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                       input bit poke, input bit keep_done);
    logic [18:0] e;
    logic [3:0]  seq1[$];
    logic [3:0]  seq0[$];
    logic [3:0]  code;
    int          lat1, lat0, want1, limit;
    e     = ref16(o, a, b);
    lat1  = 0;
    lat0  = 0;
    want1 = exp_lat(o, a, b, 1'b1);
    limit = poke ? 14 : 8;
    code  = (o == 2'b00) ? 4'b0001 : (o == 2'b01) ? 4'b0010 : (o == 2'b10) ? 4'b0011 : 4'b0100;
    for (int cyc = 1; cyc <= limit; cyc++) begin
      if (busy1) seq1.push_back(bus1.alu_op);
      if (busy0) seq0.push_back(bus0.alu_op);
      if (cyc == 1) begin
        check("busy_first_1", busy1, 1);
        check("busy_first_0", busy0, 1);
      end
      if (lat1 == 0) begin
        if (done1) begin
          lat1 = cyc;
          check("result_1", res1, e[15:0]);
          check("flags_1", fl1, e[18:16]);
        end else begin
          check("hold_1", res1, prev_res);
        end
      end else begin
        check("nodup_done_1", done1, 0);
        check("idle_busy_1", busy1, 0);
      end
      if (lat0 == 0) begin
        if (done0) begin
          lat0 = cyc;
          check("result_0", res0, e[15:0]);
          check("flags_0", fl0, e[18:16]);
        end else begin
          check("hold_0", res0, prev_res);
        end
      end else begin
        check("nodup_done_0", done0, 0);
        check("idle_busy_0", busy0, 0);
      end
      if (lat1 != 0 && lat0 != 0 && !poke) break;
      if (poke && cyc == 2) begin
        start = 1'b1;
        op    = 2'($urandom_range(0, 3));
        a_in  = 16'($urandom);
        b_in  = 16'($urandom);
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    check("latency_1", lat1, want1);
    check("latency_0", lat0, 4);
    check("seqlen_1", seq1.size(), want1 - 1);
    check("seqlen_0", seq0.size(), 3);
    for (int i = 0; i < seq1.size() && i < want1 - 1; i++)
      check("alu_op_1", seq1[i], (i == 2 && o[1]) ? 4'b1000 : code);
    for (int i = 0; i < seq0.size() && i < 3; i++)
      check("alu_op_0", seq0[i], (i == 2 && o[1]) ? 4'b1000 : code);
    prev_res = e[15:0];
    prev_fl  = e[18:16];
    if (!keep_done) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic run(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b, input bit poke);
    launch(o, a, b);
    track(o, a, b, poke, 1'b0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; a_in = 16'h0000; b_in = 16'h0000;
    prev_res = 16'h0000; prev_fl = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy1, 0);
    check("rst_done", done1, 0);
    check("rst_result", res1, 0);
    check("rst_flags", fl1, 0);
    check("rst_alu_op", bus1.alu_op, 0);
    check("rst_alu_a", bus1.alu_a, 0);
    check("rst_alu_b", bus1.alu_b, 0);
    check("rst_cin", bus1.alu_cin, 0);
    reset = 1'b0;

    run(2'b00, 16'h00FF, 16'h0001, 1'b0);
    run(2'b00, 16'h1234, 16'h0001, 1'b0);
    run(2'b00, 16'hFFFF, 16'h0001, 1'b0);
    run(2'b01, 16'h0100, 16'h0001, 1'b0);
    run(2'b01, 16'h0001, 16'h0002, 1'b0);
    run(2'b10, 16'h80C1, 16'h0000, 1'b0);
    run(2'b11, 16'h0101, 16'h0000, 1'b0);
    run(2'b01, 16'h5555, 16'h5555, 1'b1);

    // start held through DONE (ignored) and the following IDLE (accepted)
    launch(2'b10, 16'h4001, 16'h0000);
    track(2'b10, 16'h4001, 16'h0000, 1'b0, 1'b1);
    start = 1'b1; op = 2'b00; a_in = 16'h7FFF; b_in = 16'h0001;
    @(posedge clk); #1;
    check("done_start_ign_1", busy1, 0);
    check("done_start_ign_0", busy0, 0);
    @(posedge clk); #1;
    start = 1'b0;
    track(2'b00, 16'h7FFF, 16'h0001, 1'b0, 1'b0);

    // reset during HI discards the op
    launch(2'b00, 16'h12F0, 16'h3420);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_busy_1", busy1, 0);
    check("midrst_done_1", done1, 0);
    check("midrst_result_1", res1, 0);
    check("midrst_alu_op_1", bus1.alu_op, 0);
    check("midrst_busy_0", busy0, 0);
    check("midrst_result_0", res0, 0);
    check("midrst_flags_0", fl0, 0);
    prev_res = 16'h0000; prev_fl = 3'b000;
    repeat (3) begin
      @(posedge clk); #1;
      check("midrst_nodone_1", done1, 0);
      check("midrst_nodone_0", done0, 0);
    end

    for (int k = 0; k < 40; k++) begin
      logic [1:0]  ro;
      logic [15:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (k % 8 == 0) ra = 16'hFFFF;
      if (k % 8 == 1) rb = 16'h0000;
      run(ro, ra, rb, (k % 5) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
